// File: rtl/cpu_run_ctrl.sv
// CPU run/step/halt controller: gates the CPU clock enable and counts enabled cycles.
// Halts on request, breakpoint match or cycle limit, and can resume past a breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned STEP_LEN = 1
) (
    input  logic        CLK_CPU,
    input  logic        RST_CPU,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        clr,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc_in,
    input  logic [31:0] cycle_limit,
    output logic        cpu_en,
    output logic [31:0] cycle_cnt,
    output logic [1:0]  state,
    output logic [1:0]  halt_cause
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [1:0] C_NONE = 2'b00;
    localparam logic [1:0] C_HREQ = 2'b01;
    localparam logic [1:0] C_BP   = 2'b10;
    localparam logic [1:0] C_LIM  = 2'b11;
    localparam logic [7:0] L_STEP = 8'(STEP_LEN);

    state_t      r_state;
    logic [1:0]  r_cause;
    logic [31:0] r_cnt;
    logic [7:0]  r_step_cnt;
    logic        r_bp_skip;
    logic        r_run_q;
    logic        r_step_q;

    logic        w_run_edge;
    logic        w_step_edge;
    logic        w_bp_hit;
    logic        w_limit_hit;
    logic        w_run_en;
    logic        w_step_en;
    logic        w_cpu_en;
    logic [7:0]  w_step_inc;

    assign w_run_edge  = run_req & ~r_run_q;
    assign w_step_edge = step_req & ~r_step_q;
    assign w_bp_hit    = bp_en & (pc_in == bp_addr) & ~r_bp_skip;
    assign w_limit_hit = (cycle_limit != 32'd0) & (r_cnt >= cycle_limit);
    assign w_step_inc  = r_step_cnt + 8'd1;

    assign w_run_en  = (r_state == RUN) & ~halt_req & ~w_limit_hit & ~w_bp_hit;
    assign w_step_en = (r_state == STEP) & (r_step_cnt < L_STEP) & ~w_limit_hit;
    assign w_cpu_en  = w_run_en | w_step_en;

    assign cpu_en     = w_cpu_en;
    assign cycle_cnt  = r_cnt;
    assign state      = r_state;
    assign halt_cause = r_cause;

    always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
        if (RST_CPU) begin
            r_state    <= IDLE;
            r_cause    <= C_NONE;
            r_cnt      <= 32'd0;
            r_step_cnt <= 8'd0;
            r_bp_skip  <= 1'b0;
            r_run_q    <= 1'b0;
            r_step_q   <= 1'b0;
        end else begin
            r_run_q  <= run_req;
            r_step_q <= step_req;
            if (clr) begin
                r_state    <= IDLE;
                r_cause    <= C_NONE;
                r_cnt      <= 32'd0;
                r_step_cnt <= 8'd0;
                r_bp_skip  <= 1'b0;
            end else begin
                if (w_cpu_en && r_cnt != 32'hFFFF_FFFF)
                    r_cnt <= r_cnt + 32'd1;
                if (w_cpu_en)
                    r_bp_skip <= 1'b0;
                unique case (r_state)
                    IDLE, HALT: begin
                        // halt_req and limit_hit outrank a start request
                        if (!halt_req && !w_limit_hit
                            && (w_run_edge || w_step_edge)) begin
                            r_state    <= w_run_edge ? RUN : STEP;
                            r_cause    <= C_NONE;
                            r_step_cnt <= 8'd0;
                            if (r_state == HALT && r_cause == C_BP)
                                r_bp_skip <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (halt_req) begin
                            r_state <= HALT;
                            r_cause <= C_HREQ;
                        end else if (w_limit_hit) begin
                            r_state <= HALT;
                            r_cause <= C_LIM;
                        end else if (w_bp_hit) begin
                            r_state <= HALT;
                            r_cause <= C_BP;
                        end
                    end
                    STEP: begin
                        if (halt_req) begin
                            r_state <= HALT;
                            r_cause <= C_HREQ;
                        end else if (w_limit_hit) begin
                            r_state <= HALT;
                            r_cause <= C_LIM;
                        end else if (w_step_en) begin
                            r_step_cnt <= w_step_inc;
                            if (w_step_inc >= L_STEP)
                                r_state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
